oam_dma_ctrl: RTL and testbench

Sequencer and port arbiter for the 2 KB CPU work RAM that implements the $4014 sprite DMA. The CPU normally owns the RAM port. A write to the DMA register halts the CPU and copies one 256-byte RAM page into PPU OAM, after which RAM ownership returns to the CPU. The block sits between the CPU core, the CPU RAM and the PPU OAM write port.

---
 rtl/oam_dma_if.sv | 35 +++
 rtl/oam_dma_ctrl.sv | 110 +++++++++++
 tb/tb_oam_dma_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/oam_dma_if.sv
// Port bundle between the sprite DMA sequencer and the CPU, RAM and OAM.
// master = sequencer side, slave = surrounding system side.
interface oam_dma_if;
  logic [10:0] cpu_addr;
  logic        cpu_we_n;
  logic [7:0]  cpu_wdata;
  logic        cpu_odd;
  logic        reg_wr;
  logic [7:0]  reg_data;
  logic [7:0]  oam_base;
  logic [10:0] ram_addr;
  logic        ram_we_n;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        cpu_stall;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic        dma_done;
  logic        dma_err;

  modport master (
    input  cpu_addr, cpu_we_n, cpu_wdata, cpu_odd,
    input  reg_wr, reg_data, oam_base, ram_rdata,
    output ram_addr, ram_we_n, ram_wdata, cpu_stall,
    output oam_addr, oam_wdata, oam_we, dma_done, dma_err
  );

  modport slave (
    output cpu_addr, cpu_we_n, cpu_wdata, cpu_odd,
    output reg_wr, reg_data, oam_base, ram_rdata,
    input  ram_addr, ram_we_n, ram_wdata, cpu_stall,
    input  oam_addr, oam_wdata, oam_we, dma_done, dma_err
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// $4014 sprite DMA: halts the CPU and copies one 256-byte RAM page to OAM.
// The CPU owns the RAM port whenever the sequencer is idle.
module oam_dma_ctrl (
  input  logic       Clk,
  input  logic       Reset,
  oam_dma_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_ALIGN, S_READ, S_WRITE
  } state_t;

  state_t      state_q;
  logic [2:0]  page_q;
  logic [7:0]  idx_q;
  logic [7:0]  idx_d;
  logic [7:0]  base_q;
  logic        odd_q;
  logic        stall_q;
  logic        we_q;
  logic [7:0]  oaddr_q;
  logic        done_q;
  logic        err_q;
  logic        in_idle;
  logic        bad_page;
  logic        unused_bits;

  assign idx_d    = idx_q + 8'd1;
  assign in_idle  = (state_q == S_IDLE);
  assign bad_page = |bus.reg_data[7:5];

  // Pages $00-$1F alias onto the 2 KB RAM, so bits 4:3 are ignored.
  assign unused_bits = &{1'b0, bus.reg_data[4:3]};

  // Sequencer: start/reject decode, byte loop and registered strobes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      page_q  <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      odd_q   <= 1'b0;
      stall_q <= 1'b0;
      we_q    <= 1'b0;
      oaddr_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= 1'b0;
      oaddr_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.reg_wr) begin
            if (!bad_page) begin
              page_q  <= bus.reg_data[2:0];
              base_q  <= bus.oam_base;
              odd_q   <= bus.cpu_odd;
              idx_q   <= '0;
              stall_q <= 1'b1;
              state_q <= S_HALT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_HALT: begin
          state_q <= odd_q ? S_ALIGN : S_READ;
        end
        S_ALIGN: begin
          state_q <= S_READ;
        end
        S_READ: begin
          we_q    <= 1'b1;
          oaddr_q <= base_q + idx_q;
          done_q  <= (idx_q == 8'hFF);
          state_q <= S_WRITE;
        end
        S_WRITE: begin
          if (idx_q == 8'hFF) begin
            stall_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            idx_q   <= idx_d;
            state_q <= S_READ;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // RAM port mux: CPU pass-through when idle, page/idx during the copy.
  // Address is held through WRITE so the falling-edge refresh returns
  // the same byte that READ fetched.
  assign bus.ram_addr  = in_idle ? bus.cpu_addr : {page_q, idx_q};
  assign bus.ram_we_n  = in_idle ? bus.cpu_we_n : 1'b1;
  assign bus.ram_wdata = bus.cpu_wdata;

  assign bus.cpu_stall = stall_q;
  assign bus.oam_we    = we_q;
  assign bus.oam_addr  = oaddr_q;
  assign bus.oam_wdata = we_q ? bus.ram_rdata : 8'h00;
  assign bus.dma_done  = done_q;
  assign bus.dma_err   = err_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: falling-edge RAM model, OAM model and
// transfer-level reference expectations.
module tb_oam_dma_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  oam_dma_if bus ();

  oam_dma_ctrl dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] img [2048];
  logic [7:0] mem [2048];
  logic [7:0] oam [256];
  logic [7:0] rdata_q;
  logic       load = 1'b0;
  logic       oam_clr = 1'b0;

  always @(negedge Clk) begin
    if (load) begin
      for (int i = 0; i < 2048; i++) mem[i] <= img[i];
    end else begin
      rdata_q <= mem[bus.ram_addr];
      if (!bus.ram_we_n) mem[bus.ram_addr] <= bus.ram_wdata;
    end
  end
  assign bus.ram_rdata = rdata_q;

  always @(posedge Clk) begin
    if (oam_clr) begin
      for (int i = 0; i < 256; i++) oam[i] <= 8'hxx;
    end else if (bus.oam_we) begin
      oam[bus.oam_addr] <= bus.oam_wdata;
    end
  end

  task automatic drive_idle();
    bus.cpu_addr  = 11'h000;
    bus.cpu_we_n  = 1'b1;
    bus.cpu_wdata = 8'h00;
    bus.cpu_odd   = 1'b0;
    bus.reg_wr    = 1'b0;
    bus.reg_data  = 8'h00;
    bus.oam_base  = 8'h00;
  endtask

  task automatic preload(input bit ramp);
    for (int i = 0; i < 2048; i++)
      img[i] = ramp ? 8'(i) : 8'($urandom);
    @(posedge Clk); #1;
    load = 1'b1; oam_clr = 1'b1;
    @(posedge Clk); #1;
    load = 1'b0; oam_clr = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    Reset = 1'b1;
    bus.cpu_addr = 11'($urandom);
    bus.cpu_we_n = 1'b1;
    #12;
    total++;
    if (bus.cpu_stall !== 1'b0 || bus.oam_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_async stall=%b we=%b want 0 0",
               bus.cpu_stall, bus.oam_we);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    #7;
    total++;
    if (bus.oam_addr !== 8'h00 || bus.oam_wdata !== 8'h00 ||
        bus.dma_done !== 1'b0 || bus.dma_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outs addr=%h wd=%h done=%b err=%b want 0",
               bus.oam_addr, bus.oam_wdata, bus.dma_done, bus.dma_err);
    end
    total++;
    if (bus.ram_addr !== bus.cpu_addr || bus.ram_we_n !== 1'b1) begin
      bad++;
      $display("FAIL reset_pass ram_addr=%h we_n=%b want %h 1",
               bus.ram_addr, bus.ram_we_n, bus.cpu_addr);
    end
  endtask

  task automatic run_dma(input string nm, input logic [7:0] rv,
                         input logic [7:0] base, input bit odd,
                         input bit mid, input bit ramp);
    int exp_ram;
    int w;
    int stall_cnt;
    int first_we;
    int done_cnt;
    int done_bad;
    int seq_bad;
    int err_seen;
    int oam_bad;
    bit ended;
    bit mid_done;
    bit stall_prev;
    preload(ramp);
    exp_ram = int'(rv[2:0]) * 256;
    w = 0; stall_cnt = 0; first_we = 0; done_cnt = 0; done_bad = 0;
    seq_bad = 0; err_seen = 0; oam_bad = 0; ended = 0; mid_done = 0;
    stall_prev = 0;
    bus.reg_wr   = 1'b1;
    bus.reg_data = rv;
    bus.oam_base = base;
    bus.cpu_odd  = odd;
    #7;
    for (int n = 1; n <= 700; n++) begin
      @(posedge Clk); #1;
      bus.reg_wr   = 1'b0;
      bus.oam_base = 8'($urandom);
      bus.cpu_odd  = 1'($urandom);
      bus.cpu_we_n = !(stall_prev && w < 255);
      bus.cpu_addr = 11'($urandom);
      bus.cpu_wdata = 8'($urandom);
      if (mid && !mid_done && w == 100) begin
        bus.reg_wr   = 1'b1;
        bus.reg_data = 8'h05;
        mid_done = 1;
      end
      #7;
      if (bus.dma_err) err_seen++;
      if (bus.cpu_stall) begin
        stall_cnt++;
        if (bus.ram_we_n !== 1'b1) seq_bad++;
      end
      if (bus.dma_done) begin
        done_cnt++;
        if (!bus.oam_we || w != 255) done_bad++;
      end
      if (bus.oam_we) begin
        if (first_we == 0) first_we = n;
        if (bus.ram_addr !== 11'(exp_ram + w) ||
            bus.oam_addr !== 8'(int'(base) + w) ||
            bus.oam_wdata !== img[exp_ram + w]) begin
          if (seq_bad == 0)
            $display("FAIL %s_seq byte=%0d got a=%h o=%h d=%h want a=%h o=%h d=%h",
                     nm, w, bus.ram_addr, bus.oam_addr, bus.oam_wdata,
                     11'(exp_ram + w), 8'(int'(base) + w), img[exp_ram + w]);
          seq_bad++;
        end
        w++;
      end
      stall_prev = bus.cpu_stall;
      if (n > 1 && !bus.cpu_stall) begin
        ended = 1;
        break;
      end
    end
    bus.cpu_we_n = 1'b1;
    total++;
    if (!ended) begin
      bad++;
      $display("FAIL %s_timeout stall still high after 700 cycles", nm);
    end
    total++;
    if (stall_cnt != (odd ? 514 : 513)) begin
      bad++;
      $display("FAIL %s_stall got=%0d want=%0d", nm, stall_cnt,
               odd ? 514 : 513);
    end
    total++;
    if (first_we != (odd ? 4 : 3)) begin
      bad++;
      $display("FAIL %s_first_write cycle got=E+%0d want=E+%0d",
               nm, first_we, odd ? 4 : 3);
    end
    total++;
    if (w != 256) begin
      bad++;
      $display("FAIL %s_writes got=%0d want=256", nm, w);
    end
    total++;
    if (done_cnt != 1 || done_bad != 0) begin
      bad++;
      $display("FAIL %s_done count=%0d misplaced=%0d want 1 0",
               nm, done_cnt, done_bad);
    end
    total++;
    if (seq_bad != 0 || err_seen != 0) begin
      bad++;
      $display("FAIL %s_bus seq_errors=%0d err_pulses=%0d want 0 0",
               nm, seq_bad, err_seen);
    end
    for (int i = 0; i < 256; i++)
      if (oam[8'(int'(base) + i)] !== img[exp_ram + i]) oam_bad++;
    total++;
    if (oam_bad != 0) begin
      bad++;
      $display("FAIL %s_oam wrong_bytes=%0d want 0 (oam[%h]=%h want %h)",
               nm, oam_bad, base, oam[base], img[exp_ram]);
    end
  endtask

  task automatic test_err();
    int leak;
    logic [7:0] rv;
    leak = 0;
    rv = 8'h20;
    @(posedge Clk); #1;
    bus.reg_wr   = 1'b1;
    bus.reg_data = rv;
    #7;
    @(posedge Clk); #1;
    bus.reg_wr = 1'b0;
    #7;
    total++;
    if (bus.dma_err !== 1'b1 || bus.cpu_stall !== 1'b0) begin
      bad++;
      $display("FAIL err_pulse err=%b stall=%b want 1 0",
               bus.dma_err, bus.cpu_stall);
    end
    @(posedge Clk); #8;
    total++;
    if (bus.dma_err !== 1'b0) begin
      bad++;
      $display("FAIL err_width err=%b want 0", bus.dma_err);
    end
    for (int n = 0; n < 6; n++) begin
      @(posedge Clk); #8;
      if (bus.cpu_stall || bus.oam_we || bus.dma_err) leak++;
    end
    total++;
    if (leak != 0) begin
      bad++;
      $display("FAIL err_quiet active_cycles=%0d want 0", leak);
    end
    run_dma("mirror", 8'h12, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int w;
    bit hit;
    w = 0;
    hit = 0;
    preload(1'b0);
    bus.reg_wr   = 1'b1;
    bus.reg_data = 8'h03;
    bus.oam_base = 8'h00;
    bus.cpu_odd  = 1'b0;
    #7;
    for (int n = 1; n <= 300 && !hit; n++) begin
      @(posedge Clk); #1;
      bus.reg_wr = 1'b0;
      #7;
      if (bus.oam_we) begin
        if (w == 50) hit = 1;
        else w++;
      end
    end
    total++;
    if (!hit) begin
      bad++;
      $display("FAIL rst_mid_reach write 50 not seen, writes=%0d", w);
    end
    Reset = 1'b1;
    #1;
    total++;
    if (bus.cpu_stall !== 1'b0 || bus.oam_we !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_drop stall=%b we=%b want 0 0",
               bus.cpu_stall, bus.oam_we);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;
    bus.cpu_addr  = 11'h7FF;
    bus.cpu_we_n  = 1'b0;
    bus.cpu_wdata = 8'h5A;
    #7;
    total++;
    if (bus.ram_addr !== 11'h7FF || bus.ram_we_n !== 1'b0 ||
        bus.ram_wdata !== 8'h5A) begin
      bad++;
      $display("FAIL rst_mid_cpuwr addr=%h we_n=%b d=%h want 7ff 0 5a",
               bus.ram_addr, bus.ram_we_n, bus.ram_wdata);
    end
    @(posedge Clk); #1;
    bus.cpu_we_n = 1'b1;
    #7;
    total++;
    if (bus.ram_rdata !== 8'h5A || bus.cpu_stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_readback rdata=%h stall=%b want 5a 0",
               bus.ram_rdata, bus.cpu_stall);
    end
  endtask

  initial begin
    test_reset();
    run_dma("even", 8'h02, 8'h00, 1'b0, 1'b0, 1'b1);
    run_dma("odd", 8'h02, 8'h00, 1'b1, 1'b0, 1'b1);
    run_dma("wrap", 8'h01, 8'hF0, 1'b0, 1'b0, 1'b0);
    test_err();
    run_dma("midwr", 8'h04, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++)
      run_dma("rand", 8'($urandom_range(0, 31)), 8'($urandom),
              1'($urandom), 1'b0, 1'b0);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
